out_channel_drain: RTL and testbench

- Downstream consumer of the interpreter's out channel. Each `out` instruction produces one word, which is accepted here and buffered in a circular FIFO.
- Buffered words are drained to a host port with a ready/valid handshake.
- A running word count and modular checksum are kept over all accepted words. When the program finishes and the FIFO is empty, the block raises `finished` and `success`.
- Replaces the ad-hoc outMem array and end-of-program compare in FPGA test wrappers.

---
 rtl/zero_pkg.sv | 16 +
 rtl/word_fifo.sv | 65 ++++++
 rtl/out_channel_drain.sv | 123 ++++++++++++
 tb/tb_out_channel_drain.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/zero_pkg.sv
// Shared types for the interpreter out-channel drain logic.
package zero_pkg;

    // Default width of one out-channel word.
    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    // RUN: program executing; DRAIN: program done, emptying buffer; DONE: verdict held.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/word_fifo.sv
// Circular word buffer with show-ahead head, occupancy counter, full and empty flags.
module word_fifo
    import zero_pkg::*;
#(
    parameter int Width = MemoryElementWidth,
    parameter int Depth = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = $clog2(Depth + 1);
    localparam logic [CountWidth-1:0] CountFull = CountWidth'(Depth);

    logic [Width-1:0]      mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CountFull);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; a refused push leaves the array untouched.
    // NOTE: the array has no reset -- clearing the pointers and count already discards every buffered word.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so ordering inside the block is irrelevant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_channel_drain.sv
// Out-channel consumer: buffers words, drains them to the host, and judges the program's output.
module out_channel_drain #(
    parameter int MemoryElementWidth = zero_pkg::MemoryElementWidth,
    parameter int NOut               = 16,
    parameter int SumWidth           = 16,
    parameter int ExpectedCount      = 1,
    parameter int ExpectedSum        = 5,
    parameter int ExpectedFirst      = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    output logic                          drain_valid,
    output logic [MemoryElementWidth-1:0] drain_data,
    input  logic                          drain_ready,
    input  logic                          program_done,
    output logic [15:0]                   words_out,
    output logic                          overflow,
    output logic                          finished,
    output logic                          success
);

    import zero_pkg::*;

    localparam logic [15:0]                   CountTarget = 16'(ExpectedCount);
    localparam logic [SumWidth-1:0]           SumTarget   = SumWidth'(ExpectedSum);
    localparam logic [MemoryElementWidth-1:0] FirstTarget = MemoryElementWidth'(ExpectedFirst);

    drain_state_t        state;
    drain_state_t        state_next;
    logic [SumWidth-1:0] checksum;
    logic                first_seen;
    logic                first_ok;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_fire;
    logic                pop_fire;
    logic                enter_done;
    logic                verdict;

    assign out_ready   = !fifo_full;
    assign drain_valid = !fifo_empty;
    assign push_fire   = out_valid && out_ready;
    assign pop_fire    = drain_valid && drain_ready;

    word_fifo #(
        .Width (MemoryElementWidth),
        .Depth (NOut)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_fire),
        .pop   (pop_fire),
        .wdata (out_data),
        .rdata (drain_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Running statistics over accepted words, plus the sticky refused-push flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            words_out  <= '0;
            checksum   <= '0;
            first_seen <= 1'b0;
            first_ok   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                overflow <= 1'b1;
            end
            if (push_fire) begin
                if (words_out != 16'hFFFF) begin
                    words_out <= words_out + 16'd1;
                end
                checksum <= checksum + SumWidth'(out_data);
                if (!first_seen) begin
                    first_seen <= 1'b1;
                    first_ok   <= (out_data == FirstTarget);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; program_done is only sampled in RUN, so DRAIN latches it.
    // NOTE: assigning the default before the case means no path leaves state_next unassigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (program_done) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !push_fire) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    assign enter_done = (state == DRAIN) && (state_next == DONE);
    assign verdict    = !overflow && (words_out == CountTarget) && (checksum == SumTarget)
                        && ((ExpectedCount == 0) || first_ok);

    // Verdict captured once on entry to DONE and held until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            finished <= 1'b0;
            success  <= 1'b0;
        end else if (enter_done) begin
            finished <= 1'b1;
            success  <= verdict;
        end
    end

endmodule

// File: tb/tb_out_channel_drain.sv
// Directed bench: four configurations share one stimulus bus; each test checks the relevant instance.
module tb_out_channel_drain;

    logic           clock = 1'b0;
    logic           reset;
    logic           out_valid;
    zero_pkg::word_t out_data;
    logic           drain_ready;
    logic           program_done;

    // Default configuration.
    logic        a_out_ready, a_drain_valid, a_overflow, a_finished, a_success;
    logic [11:0] a_drain_data;
    logic [15:0] a_words_out;
    // NOut = 4.
    logic        b_out_ready, b_drain_valid, b_overflow, b_finished, b_success;
    logic [11:0] b_drain_data;
    logic [15:0] b_words_out;
    // SumWidth 12, two words summing to 4094, first word 4095.
    logic        c_out_ready, c_drain_valid, c_overflow, c_finished, c_success;
    logic [11:0] c_drain_data;
    logic [15:0] c_words_out;
    // Same as c but first word must be 5.
    logic        d_out_ready, d_drain_valid, d_overflow, d_finished, d_success;
    logic [11:0] d_drain_data;
    logic [15:0] d_words_out;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    out_channel_drain u_a (
        .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
        .out_ready(a_out_ready), .drain_valid(a_drain_valid), .drain_data(a_drain_data),
        .drain_ready(drain_ready), .program_done(program_done), .words_out(a_words_out),
        .overflow(a_overflow), .finished(a_finished), .success(a_success)
    );

    out_channel_drain #(.NOut(4)) u_b (
        .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
        .out_ready(b_out_ready), .drain_valid(b_drain_valid), .drain_data(b_drain_data),
        .drain_ready(drain_ready), .program_done(program_done), .words_out(b_words_out),
        .overflow(b_overflow), .finished(b_finished), .success(b_success)
    );

    out_channel_drain #(.SumWidth(12), .ExpectedCount(2), .ExpectedSum(4094), .ExpectedFirst(4095)) u_c (
        .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
        .out_ready(c_out_ready), .drain_valid(c_drain_valid), .drain_data(c_drain_data),
        .drain_ready(drain_ready), .program_done(program_done), .words_out(c_words_out),
        .overflow(c_overflow), .finished(c_finished), .success(c_success)
    );

    out_channel_drain #(.SumWidth(12), .ExpectedCount(2), .ExpectedSum(4094), .ExpectedFirst(5)) u_d (
        .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
        .out_ready(d_out_ready), .drain_valid(d_drain_valid), .drain_data(d_drain_data),
        .drain_ready(drain_ready), .program_done(program_done), .words_out(d_words_out),
        .overflow(d_overflow), .finished(d_finished), .success(d_success)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        out_valid    = 1'b0;
        out_data     = '0;
        drain_ready  = 1'b0;
        program_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #1;

        // ---- reset state ----
        apply_reset();
        check("rst_out_ready",   a_out_ready,   1);
        check("rst_drain_valid", a_drain_valid, 0);
        check("rst_words_out",   a_words_out,   0);
        check("rst_finished",    a_finished,    0);
        check("rst_overflow",    a_overflow,    0);

        // ---- single word 5, then program done ----
        out_valid   = 1'b1;
        out_data    = 12'd5;
        drain_ready = 1'b1;
        check("t1_no_bypass", a_drain_valid, 0);
        tick();
        out_valid    = 1'b0;
        program_done = 1'b1;
        check("t1_drain_valid", a_drain_valid, 1);
        check("t1_drain_data",  a_drain_data,  5);
        tick();
        check("t1_not_yet_finished", a_finished, 0);
        tick();
        check("t1_finished",  a_finished,  1);
        check("t1_success",   a_success,   1);
        check("t1_words_out", a_words_out, 1);
        // A late push in DONE is buffered but leaves the verdict alone.
        program_done = 1'b0;
        out_valid    = 1'b1;
        out_data     = 12'd9;
        tick();
        out_valid = 1'b0;
        tick();
        check("t1_done_hold_fin", a_finished,  1);
        check("t1_done_hold_suc", a_success,   1);
        check("t1_done_count",    a_words_out, 2);

        // ---- two words 3, 2: count mismatch ----
        apply_reset();
        drain_ready = 1'b1;
        out_valid   = 1'b1;
        out_data    = 12'd3;
        tick();
        check("t2_head_first", a_drain_data, 3);
        out_data = 12'd2;
        tick();
        check("t2_head_second", a_drain_data, 2);
        out_valid    = 1'b0;
        program_done = 1'b1;
        for (int i = 0; i < 20 && !a_finished; i++) tick();
        check("t2_finished",  a_finished,  1);
        check("t2_success",   a_success,   0);
        check("t2_words_out", a_words_out, 2);

        // ---- NOut=4 overflow and full push+pop ----
        apply_reset();
        out_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            out_data = 12'(i);
            tick();
        end
        check("t3_full_not_ready", b_out_ready, 0);
        check("t3_no_overflow_yet", b_overflow, 0);
        out_data = 12'd9;
        tick();
        check("t3_overflow",  b_overflow,  1);
        check("t3_words_out", b_words_out, 4);
        out_data    = 12'd7;
        drain_ready = 1'b1;
        check("t3_full_pp_ready", b_out_ready, 0);
        tick();
        out_valid   = 1'b0;
        drain_ready = 1'b0;
        check("t3_ready_after_pop", b_out_ready, 1);
        check("t3_count_after_pp",  b_words_out, 4);
        program_done = 1'b1;
        drain_ready  = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            check("t3_drain_valid", b_drain_valid, 1);
            check("t3_drain_data",  b_drain_data,  i);
            tick();
        end
        check("t3_empty_after_3", b_drain_valid, 0);
        for (int i = 0; i < 20 && !b_finished; i++) tick();
        check("t3_finished", b_finished, 1);
        check("t3_success",  b_success,  0);

        // ---- checksum wrap with SumWidth 12 ----
        apply_reset();
        drain_ready = 1'b1;
        out_valid   = 1'b1;
        out_data    = 12'd4095;
        tick();
        tick();
        out_valid    = 1'b0;
        program_done = 1'b1;
        for (int i = 0; i < 20 && !(c_finished && d_finished); i++) tick();
        check("t5_c_finished", c_finished,  1);
        check("t5_c_words",    c_words_out, 2);
        check("t5_c_success",  c_success,   1);
        check("t5_d_finished", d_finished,  1);
        check("t5_d_success",  d_success,   0);

        // ---- reset while 3 words buffered in DRAIN ----
        apply_reset();
        program_done = 1'b1;
        out_valid    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            out_data = 12'(i);
            tick();
        end
        out_valid = 1'b0;
        check("t6_buffered",     a_drain_valid, 1);
        check("t6_pre_finished", a_finished,    0);
        reset        = 1'b1;
        program_done = 1'b0;
        #1;
        check("t6_async_clear", a_drain_valid, 0);
        tick();
        reset = 1'b0;
        check("t6_drain_valid", a_drain_valid, 0);
        check("t6_finished",    a_finished,    0);
        check("t6_words_out",   a_words_out,   0);
        check("t6_overflow",    a_overflow,    0);
        check("t6_out_ready",   a_out_ready,   1);
        // Back in RUN: a drained word without program_done must not finish.
        drain_ready = 1'b1;
        out_valid   = 1'b1;
        out_data    = 12'd5;
        tick();
        out_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_run_count",    a_words_out, 1);
        check("t6_run_not_done", a_finished,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
